// File: rtl/stack_spill_fill.sv
// stack_spill_fill: backing-store controller for register_stack.
// Spills the bottom entry on overflow and refills from memory on pops.
module stack_spill_fill #(
    parameter int STACK_SIZE = 4,
    parameter int ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] SPILL_BASE = 12'hF00,
    parameter int SPILL_DEPTH = 256
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [2:0]                    stackOP,
    input  logic [15:0]                   bottom,
    output logic                          stall,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [15:0]                   mem_wdata,
    input  logic [15:0]                   mem_rdata,
    input  logic                          mem_ack,
    output logic                          fill_en,
    output logic [$clog2(STACK_SIZE)-1:0] fill_idx,
    output logic [15:0]                   fill_data,
    output logic                          overflow,
    output logic                          underflow,
    output logic [15:0]                   depth
);
    localparam int CW = $clog2(STACK_SIZE + 1);
    localparam int SW = $clog2(SPILL_DEPTH + 1);
    localparam int IW = $clog2(STACK_SIZE);
    localparam logic [CW-1:0] FULL = CW'(STACK_SIZE);
    localparam logic [SW-1:0] SMAX = SW'(SPILL_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SPILL   = 2'd1;
    localparam logic [1:0] FILL    = 2'd2;
    localparam logic [1:0] FILL_WB = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] reg_count;
    logic [SW-1:0] sp;
    logic [1:0]    k;
    logic [1:0]    n;
    logic [1:0]    j;
    logic [1:0]    k_in;
    logic [1:0]    n_in;

    // Pop width of the incoming op and how many of those slots memory can refill.
    always_comb begin
        k_in = 2'd0;
        n_in = 2'd0;
        case (stackOP)
            3'd2, 3'd3: k_in = 2'd1;
            3'd4:       k_in = 2'd2;
            default:    k_in = 2'd0;
        endcase
        if (sp >= SW'(k_in)) n_in = k_in;
        else                 n_in = 2'(sp);
    end

    // Control FSM plus occupancy counters; ops are only accepted in IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            reg_count <= '0;
            sp        <= '0;
            k         <= '0;
            n         <= '0;
            j         <= '0;
            mem_wdata <= '0;
            fill_data <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stackOP == 3'd1) begin
                        if (reg_count < FULL) begin
                            reg_count <= reg_count + CW'(1);
                        end else if (sp < SMAX) begin
                            mem_wdata <= bottom;
                            state     <= SPILL;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (k_in != 2'd0) begin
                        if (CW'(k_in) > reg_count) begin
                            underflow <= 1'b1;
                            reg_count <= '0;
                        end else if (sp != '0) begin
                            reg_count <= FULL - CW'(k_in) + CW'(n_in);
                            k         <= k_in;
                            n         <= n_in;
                            j         <= 2'd0;
                            state     <= FILL;
                        end else begin
                            reg_count <= reg_count - CW'(k_in);
                        end
                    end
                end
                SPILL: begin
                    if (mem_ack) begin
                        sp    <= sp + SW'(1);
                        state <= IDLE;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        fill_data <= mem_rdata;
                        sp        <= sp - SW'(1);
                        state     <= FILL_WB;
                    end
                end
                default: begin
                    if (j + 2'd1 < n) begin
                        j     <= j + 2'd1;
                        state <= FILL;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Memory and register-stack strobes decoded from the registered state.
    always_comb begin
        stall    = (state != IDLE);
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        fill_en  = 1'b0;
        fill_idx = '0;
        case (state)
            SPILL: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = SPILL_BASE + ADDR_WIDTH'(sp);
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = SPILL_BASE + ADDR_WIDTH'(sp) - ADDR_WIDTH'(1);
            end
            FILL_WB: begin
                fill_en  = 1'b1;
                fill_idx = IW'(STACK_SIZE - int'(k) + int'(j));
            end
            default: ;
        endcase
        depth = 16'(reg_count) + 16'(sp);
    end
endmodule

// File: tb/tb_stack_spill_fill.sv
// tb_stack_spill_fill: directed and random checks against a logical-stack model.
// Register stack is the top of a value queue; memory holds the rest.
module tb_stack_spill_fill;
    localparam int S = 4;
    localparam logic [11:0] BASE = 12'hF00;

    logic        CLK = 0;
    logic        RST = 0;
    logic        sel = 0;
    logic [2:0]  stackOP = 0;
    logic [15:0] bottom = 0;
    logic [15:0] mem_rdata = 0;
    logic        mem_ack = 0;

    logic        st1, rq1, we1, fe1, ov1, un1;
    logic        st2, rq2, we2, fe2, ov2, un2;
    logic [11:0] ad1, ad2;
    logic [15:0] wd1, wd2, fd1, fd2, dp1, dp2;
    logic [1:0]  fi1, fi2;

    stack_spill_fill dut1 (
        .CLK(CLK), .RST(RST), .stackOP(sel ? 3'd0 : stackOP), .bottom(bottom),
        .stall(st1), .mem_req(rq1), .mem_we(we1), .mem_addr(ad1), .mem_wdata(wd1),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack & ~sel), .fill_en(fe1), .fill_idx(fi1),
        .fill_data(fd1), .overflow(ov1), .underflow(un1), .depth(dp1)
    );

    stack_spill_fill #(.SPILL_DEPTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .stackOP(sel ? stackOP : 3'd0), .bottom(bottom),
        .stall(st2), .mem_req(rq2), .mem_we(we2), .mem_addr(ad2), .mem_wdata(wd2),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack & sel), .fill_en(fe2), .fill_idx(fi2),
        .fill_data(fd2), .overflow(ov2), .underflow(un2), .depth(dp2)
    );

    wire        o_st = sel ? st2 : st1;
    wire        o_rq = sel ? rq2 : rq1;
    wire        o_we = sel ? we2 : we1;
    wire        o_fe = sel ? fe2 : fe1;
    wire        o_ov = sel ? ov2 : ov1;
    wire        o_un = sel ? un2 : un1;
    wire [11:0] o_ad = sel ? ad2 : ad1;
    wire [15:0] o_wd = sel ? wd2 : wd1;
    wire [15:0] o_fd = sel ? fd2 : fd1;
    wire [15:0] o_dp = sel ? dp2 : dp1;
    wire [1:0]  o_fi = sel ? fi2 : fi1;

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    logic [15:0] lq[$];
    logic [15:0] memarr [0:4095];
    int dmax = 256;
    bit eov = 0;
    bit eun = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        lq.delete();
        eov = 0;
        eun = 0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] v, input int ackwait);
        int len, rc, spc, k, n, w, nreq, nfill, cyc;
        bit estall, sawst;
        logic [11:0] ea[$];
        logic        ewe[$];
        logic [15:0] ed[$];
        int          fx[$];
        logic [15:0] fv[$];
        logic [15:0] t;
        len = lq.size();
        rc = (len < S) ? len : S;
        spc = len - rc;
        k = (op == 3'd2 || op == 3'd3) ? 1 : (op == 3'd4) ? 2 : 0;
        bottom = (len >= S) ? lq[S-1] : 16'($urandom());
        estall = 0;
        if (op == 3'd1) begin
            if (len < S) begin
                lq.push_front(v);
            end else if (spc < dmax) begin
                ea.push_back(BASE + 12'(spc));
                ewe.push_back(1'b1);
                ed.push_back(lq[S-1]);
                lq.push_front(v);
                estall = 1;
            end else begin
                eov = 1;
                lq.delete(S-1);
                lq.push_front(v);
            end
        end else if (k > 0) begin
            if (k > rc) begin
                eun = 1;
                lq.delete();
            end else begin
                n = (k < spc) ? k : spc;
                for (int i = 0; i < n; i++) begin
                    ea.push_back(BASE + 12'(spc - 1 - i));
                    ewe.push_back(1'b0);
                    ed.push_back(16'h0);
                end
                for (int i = 0; i < k; i++) void'(lq.pop_front());
                for (int i = 0; i < n; i++) begin
                    fx.push_back(S - k + i);
                    fv.push_back(lq[S-k+i]);
                end
                if (op == 3'd2 && lq.size() > 0) lq[0] = v;
                estall = (n > 0);
            end
        end else if (op == 3'd5 && len >= 2) begin
            t = lq[0];
            lq[0] = lq[1];
            lq[1] = t;
        end
        stackOP = op;
        @(posedge CLK); #1;
        stackOP = 0;
        nreq = 0;
        nfill = 0;
        sawst = 0;
        w = (ackwait < 0) ? int'($urandom_range(0, 2)) : ackwait;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLK);
            if (!o_st) break;
            sawst = 1;
            if (o_rq) begin
                if (nreq < ea.size()) begin
                    chk("mem_addr", 32'(o_ad), 32'(ea[nreq]));
                    chk("mem_we", 32'(o_we), 32'(ewe[nreq]));
                    if (ewe[nreq]) chk("mem_wdata", 32'(o_wd), 32'(ed[nreq]));
                end else begin
                    chk("extra_req", 32'(o_rq), 32'd0);
                end
                if (w == 0) begin
                    mem_ack = 1;
                    if (o_we) begin
                        memarr[o_ad] = o_wd;
                        mem_rdata = 16'($urandom());
                    end else begin
                        mem_rdata = memarr[o_ad];
                    end
                    nreq++;
                    w = (ackwait < 0) ? int'($urandom_range(0, 2)) : ackwait;
                end else begin
                    w--;
                end
            end
            if (o_fe) begin
                if (nfill < fx.size()) begin
                    chk("fill_idx", 32'(o_fi), 32'(fx[nfill]));
                    chk("fill_data", 32'(o_fd), 32'(fv[nfill]));
                end else begin
                    chk("extra_fill", 32'(o_fe), 32'd0);
                end
                nfill++;
            end
            @(posedge CLK); #1;
            mem_ack = 0;
        end
        if (cyc >= 40) chk("stall_timeout", 32'(o_st), 32'd0);
        chk("stall_seen", 32'(sawst), 32'(estall));
        chk("req_count", 32'(nreq), 32'(ea.size()));
        chk("fill_count", 32'(nfill), 32'(fx.size()));
        chk("idle_req", 32'(o_rq), 32'd0);
        chk("idle_fill", 32'(o_fe), 32'd0);
        chk("depth", 32'(o_dp), 32'(lq.size()));
        chk("overflow", 32'(o_ov), 32'(eov));
        chk("underflow", 32'(o_un), 32'(eun));
        @(posedge CLK); #1;
    endtask

    initial begin
        int r;
        logic [2:0] op;
        for (int i = 0; i < 4096; i++) memarr[i] = 16'h0;

        do_reset();
        @(negedge CLK);
        chk("rst_depth", 32'(o_dp), 32'd0);
        chk("rst_stall", 32'(o_st), 32'd0);
        chk("rst_req", 32'(o_rq), 32'd0);
        chk("rst_fill", 32'(o_fe), 32'd0);
        chk("rst_ovf", 32'(o_ov), 32'd0);
        chk("rst_unf", 32'(o_un), 32'd0);
        @(posedge CLK); #1;

        run_op(3'd1, 16'hAAAA, 0);
        run_op(3'd1, 16'hBBBB, 0);
        run_op(3'd1, 16'hCCCC, 0);
        run_op(3'd1, 16'hDDDD, 0);
        run_op(3'd1, 16'hEEEE, 2);

        bottom = lq[S-1];
        stackOP = 3'd1;
        @(posedge CLK); #1;
        stackOP = 0;
        @(negedge CLK);
        chk("midspill_req", 32'(o_rq), 32'd1);
        chk("midspill_addr", 32'(o_ad), 32'hF01);
        #1 RST = 1;
        #1;
        chk("arst_req", 32'(o_rq), 32'd0);
        chk("arst_stall", 32'(o_st), 32'd0);
        chk("arst_depth", 32'(o_dp), 32'd0);
        @(posedge CLK); #1;
        RST = 0;
        lq.delete();
        eov = 0;
        eun = 0;

        run_op(3'd1, 16'h1111, 0);
        run_op(3'd1, 16'h2222, 0);
        run_op(3'd1, 16'h3333, 0);
        run_op(3'd1, 16'h4444, 0);
        run_op(3'd1, 16'h5555, 1);
        run_op(3'd1, 16'h6666, 0);
        run_op(3'd3, 16'h0, 0);

        do_reset();
        run_op(3'd1, 16'h1111, 0);
        run_op(3'd1, 16'h2222, 0);
        run_op(3'd1, 16'h3333, 0);
        run_op(3'd1, 16'h4444, 0);
        run_op(3'd1, 16'h5555, 0);
        run_op(3'd1, 16'h6666, 0);
        run_op(3'd4, 16'h0, 1);

        do_reset();
        run_op(3'd1, 16'h0123, 0);
        run_op(3'd4, 16'h0, 0);
        run_op(3'd5, 16'h0, 0);
        run_op(3'd7, 16'h0, 0);

        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      op = 3'd1;
            else if (r < 60) op = 3'd3;
            else if (r < 70) op = 3'd2;
            else if (r < 82) op = 3'd4;
            else if (r < 90) op = 3'd5;
            else if (r < 94) op = 3'd0;
            else if (r < 97) op = 3'd6;
            else             op = 3'd7;
            run_op(op, 16'($urandom()), -1);
        end

        sel = 1;
        dmax = 2;
        do_reset();
        for (int i = 0; i < 7; i++) run_op(3'd1, 16'(16'h7000 + i), -1);
        chk("d2_overflow", 32'(o_ov), 32'd1);
        chk("d2_depth", 32'(o_dp), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
